drum_shift_restore: RTL
=======================

# drum_shift_restore

Output end of the DRUM approximate multiplier datapath. The leading-one detectors on the input side produce a one-hot leading-one mask per operand. This block encodes each mask to a binary bit position and derives the truncation shift. It then left-shifts the K×K truncated product back to full SIZE×SIZE scale and returns the approximate product through a 2-stage valid/ready pipeline.

## Interface
Parameters:
- SIZE, 8: operand width; the product is 2*SIZE bits.
- K, 4: DRUM truncation width, 2 ≤ K ≤ SIZE; the truncated product is 2*K bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat when in_valid && in_ready.
- lo_a  input  SIZE  one-hot leading-one mask of operand A; all-zero means A == 0.
- lo_b  input  SIZE  one-hot leading-one mask of operand B.
- trunc_prod  input  2*K  product of the two K-bit truncated operands.
- out_valid  output  1  out_product valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- out_product  output  2*SIZE  approximate product.
- onehot_err  output  1  sticky flag: a lo_a/lo_b mask with more than one bit set was accepted.

## Operation
- Stage 1, encode, registered:
  - pos_x = index of the highest set bit of lo_x, using a priority encode from the MSB.
  - zero_x = (lo_x == 0).
  - sh_x = (pos_x ≥ K) ? pos_x−K+1 : 0, width clog2(SIZE).
  - Registered values: sh_sum = sh_a + sh_b (max 2*(SIZE−K)), zero = zero_a | zero_b, and trunc_prod.
- Stage 2, restore, registered:
  - out_product = zero ? 0 : zero-extend(trunc_prod) << sh_sum.
  - The shift is computed in 2*SIZE bits; any bits shifted out are discarded. Correct upstream input never produces shifted-out bits.
- The block does no arithmetic on trunc_prod beyond the shift. LSB forcing and truncation happen upstream.
- Pipeline rules:
  - Each stage holds a valid bit.
  - Stage 2 advances when !s2_valid || out_ready.
  - Stage 1 advances when !s1_valid || stage 2 advances.
  - in_ready = stage-1 advance condition, which is combinational from out_ready.
  - Data registers load only on advance. Output data is stable while out_valid && !out_ready.
- Multi-bit masks:
  - Encoding always uses the highest set bit.
  - onehot_err is set when such a beat is accepted (only with the macro enabled; see Configuration).

## Timing
- Latency: 2 cycles from acceptance to out_valid when there is no backpressure. Throughput is 1 beat per cycle.
- Reset (rst_n low at a clock edge):
  - s1_valid = 0, s2_valid = 0, out_valid = 0, out_product = 0, onehot_err = 0.
  - in_ready reads 1 in the cycle after reset is released.
- Reset mid-operation: all in-flight beats are dropped with no partial output. Reset has priority over every other event.
- Full pipeline with out_ready = 0:
  - in_ready = 0.
  - No beat is lost or duplicated.
  - When out_ready rises, in_ready rises in the same cycle.
- Simultaneous accept and emit: in the same cycle stage 2 emits, stage 1 moves to stage 2, and a new beat loads into stage 1.
- in_valid is ignored while in_ready = 0. The upstream holds its data.

## Configuration
- DRUM_ONEHOT_CHECK_EN defined:
  - Per-operand popcount>1 detection is compiled in.
  - onehot_err is set on acceptance of a bad beat and clears only on reset.
- DRUM_ONEHOT_CHECK_EN undefined:
  - The detection logic is absent and onehot_err is tied to 0.
  - Datapath behaviour is identical, including the priority encode.

## Test plan
All scenarios use SIZE=8, K=4.
- Basic restore: lo_a=8'h80 (A=182), lo_b=8'h04 (B=5), trunc_prod=8'd55 -> out_product=16'd880 exactly 2 cycles after acceptance; in_ready stays 1.
- Zero operand: lo_a=8'h00, lo_b=8'h40, trunc_prod=8'hFF -> out_product=0.
- Maximum shift: lo_a=lo_b=8'h80, trunc_prod=8'hE1 -> sh_sum=8, out_product=16'hE100.
- Backpressure: stream 4 back-to-back beats while out_ready=0 for 5 cycles -> in_ready drops after 2 beats are accepted. After out_ready=1, all 4 products appear in order with no gaps or duplicates.
- Bad mask: lo_a=8'h90, lo_b=8'h01, trunc_prod=8'd9 -> out_product=16'd144 (shift 4).
  - With the macro: onehot_err=1 and stays 1 until reset.
  - Without the macro: onehot_err=0.
- Reset mid-stream: assert rst_n=0 for 1 cycle with both stages full -> out_valid=0 and out_product=0 the next cycle, and no stale beat ever emerges.

Source files
------------

// File: rtl/drum_shift_restore.sv
// DRUM multiplier output end: encodes leading-one masks to shift amounts and restores the product scale.
// Optional macro DRUM_ONEHOT_CHECK_EN compiles in the sticky multi-bit mask detector (onehot_err).
module drum_shift_restore #(
    parameter int SIZE = 8,
    parameter int K    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE-1:0]     lo_a,
    input  logic [SIZE-1:0]     lo_b,
    input  logic [2*K-1:0]      trunc_prod,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*SIZE-1:0]   out_product,
    output logic                onehot_err
);

    localparam int SHW = $clog2(SIZE);
    localparam int SSW = $clog2(2 * SIZE);

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    function automatic logic [SHW-1:0] mask_shift(input logic [SIZE-1:0] mask);
        int pos;
        pos = 0;
        for (int i = 0; i < SIZE; i++) begin
            if (mask[i]) pos = i;
        end
        return (pos >= K) ? SHW'(pos - K + 1) : '0;
    endfunction

    logic [SHW-1:0]    sh_a;
    logic [SHW-1:0]    sh_b;
    logic [SSW-1:0]    sh_sum;
    logic              s1_adv;
    logic              s2_adv;
    logic              s1_valid_reg;
    logic [SSW-1:0]    s1_sh_sum_reg;
    logic              s1_zero_reg;
    logic [2*K-1:0]    s1_prod_reg;
    logic              s2_valid_reg;
    logic [2*SIZE-1:0] product_reg;
    logic [2*SIZE-1:0] prod_wide;
    logic [2*SIZE-1:0] restored;

    assign sh_a   = mask_shift(lo_a);
    assign sh_b   = mask_shift(lo_b);
    assign sh_sum = SSW'(sh_a) + SSW'(sh_b);

    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        prod_wide = '0;
        prod_wide[2*K-1:0] = s1_prod_reg;
    end

    assign restored = s1_zero_reg ? '0 : (prod_wide << s1_sh_sum_reg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_sh_sum_reg <= '0;
            s1_zero_reg   <= 1'b0;
            s1_prod_reg   <= '0;
            s2_valid_reg  <= 1'b0;
            product_reg   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_reg <= in_valid;
                if (in_valid) begin
                    s1_sh_sum_reg <= sh_sum;
                    s1_zero_reg   <= (lo_a == '0) || (lo_b == '0);
                    s1_prod_reg   <= trunc_prod;
                end
            end
            // Output data only changes on a real load, keeping it stable under backpressure.
            if (s2_adv) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) product_reg <= restored;
            end
        end
    end

    assign out_valid   = s2_valid_reg;
    assign out_product = product_reg;

`ifdef DRUM_ONEHOT_CHECK_EN
    logic multi_a;
    logic multi_b;
    logic onehot_err_reg;

    // x & (x-1) clears the lowest set bit; anything left means two or more bits were set.
    assign multi_a = (lo_a & (lo_a - SIZE'(1))) != '0;
    assign multi_b = (lo_b & (lo_b - SIZE'(1))) != '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            onehot_err_reg <= 1'b0;
        end else if (in_valid && s1_adv && (multi_a || multi_b)) begin
            onehot_err_reg <= 1'b1;
        end
    end

    assign onehot_err = onehot_err_reg;
`else
    assign onehot_err = 1'b0;
`endif

endmodule
